uart_tx_framed: RTL

//  Parametrised UART transmitter with a valid/ready byte interface.
//  - Configurable data width, parity mode and stop-bit count.
//  - Serialises one word per frame onto tx_serial, LSB first; line idles high.
//  - Sits between host-side logic (e.g. a TX FIFO or debug dump engine) and the board UART pin.
//  - Reports busy state and a per-frame completion pulse.

---
 rtl/uart_tx_framed.sv | 127 ++++++++++++
 1 files changed

// File: rtl/uart_tx_framed.sv
// UART transmitter with valid/ready word input, configurable data width, parity and stop bits.
// Frames go out LSB first behind a low start bit; the line idles high between frames.
module uart_tx_framed #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]           state, state_n;
  logic [CW-1:0]        clk_cnt, clk_cnt_n;
  logic [BW-1:0]        bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_bit, par_bit_n;
  logic                 serial_n;
  logic                 accept;
  logic                 bit_end;
  logic                 par_calc;

  assign tx_ready = (state == S_IDLE) && !rst;
  assign accept   = tx_valid && tx_ready;
  assign tx_busy  = (state != S_IDLE);
  assign bit_end  = (clk_cnt == CLK_LAST);
  assign tx_done  = (state == S_STOP) && bit_end && (bit_cnt == STOP_LAST);
  assign par_calc = (PARITY == 1) ? ~^tx_data : ^tx_data;

  // Next-state logic; the line level is derived from the next state so tx_serial is a plain flop.
  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_bit_n = par_bit;
    if (state == S_IDLE) begin
      if (accept) begin
        state_n   = S_START;
        shreg_n   = tx_data;
        par_bit_n = par_calc;
        clk_cnt_n = '0;
        bit_cnt_n = '0;
      end
    end else if (!bit_end) begin
      clk_cnt_n = clk_cnt + 1'b1;
    end else begin
      clk_cnt_n = '0;
      case (state)
        S_START: begin
          state_n   = S_DATA;
          bit_cnt_n = '0;
        end
        S_DATA: begin
          if (bit_cnt == DATA_LAST) begin
            state_n   = (PARITY != 0) ? S_PARITY : S_STOP;
            bit_cnt_n = '0;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
            shreg_n   = shreg >> 1;
          end
        end
        S_PARITY: begin
          state_n   = S_STOP;
          bit_cnt_n = '0;
        end
        S_STOP: begin
          if (bit_cnt == STOP_LAST) begin
            state_n   = S_IDLE;
            bit_cnt_n = '0;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
        default: begin
          state_n   = S_IDLE;
          bit_cnt_n = '0;
        end
      endcase
    end

    case (state_n)
      S_START:  serial_n = 1'b0;
      S_DATA:   serial_n = shreg_n[0];
      S_PARITY: serial_n = par_bit_n;
      default:  serial_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      tx_serial <= 1'b1;
    end else begin
      state     <= state_n;
      clk_cnt   <= clk_cnt_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      par_bit   <= par_bit_n;
      tx_serial <= serial_n;
    end
  end

endmodule
